instruction_decode: RTL and testbench

Decode stage of the 5-stage RV32I pipeline, directly downstream of the instruction-fetch stage. It holds the IF/ID pipeline register, the 32x32 register file, and the immediate/control decoder, and registers everything into the ID/EX pipeline register. It also detects load-use hazards, drives the fetch stage's PC enable, and applies branch flushes signalled from EX.

---
 rtl/instruction_decode_if.sv | 46 ++++
 rtl/instruction_decode.sv | 239 +++++++++++++++++++++++
 tb/tb_instruction_decode.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_decode_if.sv
// Bundle of fetch-side, writeback and ID/EX signals around the decode stage.
interface instruction_decode_if;
  logic [31:0] if_pc;
  logic [31:0] if_instrn;
  logic        PCSrc;
  logic        wb_regWrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        PCEnable;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1Data;
  logic [31:0] ex_rs2Data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_aluCtrl;
  logic        ex_regWrite;
  logic        ex_memRead;
  logic        ex_memWrite;
  logic        ex_memToReg;
  logic        ex_aluSrc;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_jalr;
  logic        ex_lui;
  logic        ex_auipc;

  // Fetch/writeback/EX side: drives instructions, flushes and writebacks.
  modport master (
    output if_pc, if_instrn, PCSrc, wb_regWrite, wb_rd, wb_data,
    input  PCEnable, ex_pc, ex_rs1Data, ex_rs2Data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_aluCtrl, ex_regWrite, ex_memRead, ex_memWrite,
           ex_memToReg, ex_aluSrc, ex_branch, ex_jump, ex_jalr, ex_lui,
           ex_auipc
  );

  // Decode stage side.
  modport slave (
    input  if_pc, if_instrn, PCSrc, wb_regWrite, wb_rd, wb_data,
    output PCEnable, ex_pc, ex_rs1Data, ex_rs2Data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_aluCtrl, ex_regWrite, ex_memRead, ex_memWrite,
           ex_memToReg, ex_aluSrc, ex_branch, ex_jump, ex_jalr, ex_lui,
           ex_auipc
  );
endinterface

// File: rtl/instruction_decode.sv
// RV32I decode stage: IF/ID register, 32x32 register file with write-through
// bypass, immediate/control decoder, load-use hazard detection and ID/EX
// register. Branch flushes from EX kill both the IF/ID and decoding slots.
module instruction_decode (
  input logic clk,
  input logic rst_,
  instruction_decode_if.slave bus
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;

  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [31:0] regs [32];

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd_field;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic        dec_regWrite, dec_memRead, dec_memWrite, dec_memToReg, dec_aluSrc;
  logic        dec_branch, dec_jump, dec_jalr, dec_lui, dec_auipc;
  logic [4:0]  dec_rd;
  logic [3:0]  dec_aluCtrl;
  logic [31:0] dec_imm;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic        uses_rs2;
  logic        stall;
  logic        flush;

  assign opcode   = if_id_instr[6:0];
  assign f3       = if_id_instr[14:12];
  assign rs1      = if_id_instr[19:15];
  assign rs2      = if_id_instr[24:20];
  assign rd_field = if_id_instr[11:7];

  assign imm_i = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
  assign imm_s = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
  assign imm_b = {{19{if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                  if_id_instr[30:25], if_id_instr[11:8], 1'b0};
  assign imm_u = {if_id_instr[31:12], 12'b0};
  assign imm_j = {{11{if_id_instr[31]}}, if_id_instr[31], if_id_instr[19:12],
                  if_id_instr[20], if_id_instr[30:21], 1'b0};

  // Only R, store and branch formats actually read rs2; other formats reuse
  // those bits as immediate and must not raise false hazards.
  assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign stall    = bus.ex_memRead && (bus.ex_rd != 5'd0) &&
                    ((bus.ex_rd == rs1) || (uses_rs2 && (bus.ex_rd == rs2)));
  assign flush    = bus.PCSrc;
  assign bus.PCEnable = ~stall | flush;

  // IF/ID register: flush inserts a NOP, stall holds, otherwise capture fetch.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP;
    end else if (flush) begin
      if_id_pc    <= 32'd0;
      if_id_instr <= NOP;
    end else if (!stall) begin
      if_id_pc    <= bus.if_pc;
      if_id_instr <= bus.if_instrn;
    end
  end

  // Register file write port; x0 is never written and writes complete during stalls.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (bus.wb_regWrite && (bus.wb_rd != 5'd0)) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Register file read ports with write-through bypass from writeback.
  always_comb begin
    rs1_data = regs[rs1];
    rs2_data = regs[rs2];
    if (rs1 == 5'd0) rs1_data = 32'd0;
    else if (bus.wb_regWrite && (bus.wb_rd == rs1)) rs1_data = bus.wb_data;
    if (rs2 == 5'd0) rs2_data = 32'd0;
    else if (bus.wb_regWrite && (bus.wb_rd == rs2)) rs2_data = bus.wb_data;
  end

  // Opcode decode; unknown opcodes fall through as a bubble.
  always_comb begin
    dec_regWrite = 1'b0;
    dec_memRead  = 1'b0;
    dec_memWrite = 1'b0;
    dec_memToReg = 1'b0;
    dec_aluSrc   = 1'b0;
    dec_branch   = 1'b0;
    dec_jump     = 1'b0;
    dec_jalr     = 1'b0;
    dec_lui      = 1'b0;
    dec_auipc    = 1'b0;
    dec_rd       = 5'd0;
    dec_aluCtrl  = 4'd0;
    dec_imm      = 32'd0;
    case (opcode)
      OP_R: begin
        dec_regWrite = 1'b1;
        dec_rd       = rd_field;
        dec_aluCtrl  = {if_id_instr[30], f3};
      end
      OP_IMM: begin
        dec_regWrite = 1'b1;
        dec_aluSrc   = 1'b1;
        dec_rd       = rd_field;
        // bit 30 only distinguishes SRAI from SRLI; elsewhere it is immediate.
        dec_aluCtrl  = {(f3 == 3'b101) ? if_id_instr[30] : 1'b0, f3};
        dec_imm      = imm_i;
      end
      OP_LOAD: begin
        dec_regWrite = 1'b1;
        dec_memRead  = 1'b1;
        dec_memToReg = 1'b1;
        dec_aluSrc   = 1'b1;
        dec_rd       = rd_field;
        dec_imm      = imm_i;
      end
      OP_STORE: begin
        dec_memWrite = 1'b1;
        dec_aluSrc   = 1'b1;
        dec_rd       = rd_field;
        dec_imm      = imm_s;
      end
      OP_BRANCH: begin
        dec_branch  = 1'b1;
        dec_rd      = rd_field;
        dec_aluCtrl = {1'b0, f3};
        dec_imm     = imm_b;
      end
      OP_JAL: begin
        dec_jump     = 1'b1;
        dec_regWrite = 1'b1;
        dec_rd       = rd_field;
        dec_imm      = imm_j;
      end
      OP_JALR: begin
        dec_jalr     = 1'b1;
        dec_regWrite = 1'b1;
        dec_aluSrc   = 1'b1;
        dec_rd       = rd_field;
        dec_imm      = imm_i;
      end
      OP_LUI: begin
        dec_lui      = 1'b1;
        dec_regWrite = 1'b1;
        dec_rd       = rd_field;
        dec_imm      = imm_u;
      end
      OP_AUIPC: begin
        dec_auipc    = 1'b1;
        dec_regWrite = 1'b1;
        dec_rd       = rd_field;
        dec_imm      = imm_u;
      end
      default: ;
    endcase
  end

  // ID/EX register: flush or stall injects an all-zero bubble.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_ ) begin
      bus.ex_pc       <= 32'd0;
      bus.ex_rs1Data  <= 32'd0;
      bus.ex_rs2Data  <= 32'd0;
      bus.ex_imm      <= 32'd0;
      bus.ex_rs1      <= 5'd0;
      bus.ex_rs2      <= 5'd0;
      bus.ex_rd       <= 5'd0;
      bus.ex_aluCtrl  <= 4'd0;
      bus.ex_regWrite <= 1'b0;
      bus.ex_memRead  <= 1'b0;
      bus.ex_memWrite <= 1'b0;
      bus.ex_memToReg <= 1'b0;
      bus.ex_aluSrc   <= 1'b0;
      bus.ex_branch   <= 1'b0;
      bus.ex_jump     <= 1'b0;
      bus.ex_jalr     <= 1'b0;
      bus.ex_lui      <= 1'b0;
      bus.ex_auipc    <= 1'b0;
    end else if (flush || stall) begin
      bus.ex_pc       <= 32'd0;
      bus.ex_rs1Data  <= 32'd0;
      bus.ex_rs2Data  <= 32'd0;
      bus.ex_imm      <= 32'd0;
      bus.ex_rs1      <= 5'd0;
      bus.ex_rs2      <= 5'd0;
      bus.ex_rd       <= 5'd0;
      bus.ex_aluCtrl  <= 4'd0;
      bus.ex_regWrite <= 1'b0;
      bus.ex_memRead  <= 1'b0;
      bus.ex_memWrite <= 1'b0;
      bus.ex_memToReg <= 1'b0;
      bus.ex_aluSrc   <= 1'b0;
      bus.ex_branch   <= 1'b0;
      bus.ex_jump     <= 1'b0;
      bus.ex_jalr     <= 1'b0;
      bus.ex_lui      <= 1'b0;
      bus.ex_auipc    <= 1'b0;
    end else begin
      bus.ex_pc       <= if_id_pc;
      bus.ex_rs1Data  <= rs1_data;
      bus.ex_rs2Data  <= rs2_data;
      bus.ex_imm      <= dec_imm;
      bus.ex_rs1      <= rs1;
      bus.ex_rs2      <= rs2;
      bus.ex_rd       <= dec_rd;
      bus.ex_aluCtrl  <= dec_aluCtrl;
      bus.ex_regWrite <= dec_regWrite;
      bus.ex_memRead  <= dec_memRead;
      bus.ex_memWrite <= dec_memWrite;
      bus.ex_memToReg <= dec_memToReg;
      bus.ex_aluSrc   <= dec_aluSrc;
      bus.ex_branch   <= dec_branch;
      bus.ex_jump     <= dec_jump;
      bus.ex_jalr     <= dec_jalr;
      bus.ex_lui      <= dec_lui;
      bus.ex_auipc    <= dec_auipc;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: expected ID/EX contents are
// queued when an instruction is driven and compared when they are due.
module tb_instruction_decode;

  logic clk;
  logic rst_;
  int   checks;
  int   failures;
  int   cyc;

  instruction_decode_if bus ();

  instruction_decode dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI_X1  = 32'h0050_0093;
  localparam logic [31:0] SRAI_X4  = 32'h4030_D213;
  localparam logic [31:0] SUB_X5   = 32'h4020_82B3;
  localparam logic [31:0] ILLEGAL  = 32'hFFFF_FFFF;
  localparam logic [31:0] LW_X2    = 32'h0000_A103;
  localparam logic [31:0] LW_X5    = 32'h0000_A283;
  localparam logic [31:0] ADD_X3   = 32'h0021_01B3;
  localparam logic [31:0] SW_X2    = 32'hFE20_AE23;
  localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;
  localparam logic [31:0] JAL_X1   = 32'h0010_00EF;
  localparam logic [31:0] LUI_X1   = 32'h1234_50B7;
  localparam logic [31:0] ADD_X6   = 32'h0002_8333;
  localparam logic [31:0] ADD_X7   = 32'h0050_03B3;

  // ctrl order: regWrite memRead memWrite memToReg aluSrc branch jump jalr lui auipc
  localparam logic [9:0] C_ALUI   = 10'h220;
  localparam logic [9:0] C_R      = 10'h200;
  localparam logic [9:0] C_LOAD   = 10'h360;
  localparam logic [9:0] C_STORE  = 10'h0A0;
  localparam logic [9:0] C_BRANCH = 10'h010;
  localparam logic [9:0] C_JAL    = 10'h208;
  localparam logic [9:0] C_LUI    = 10'h202;

  typedef struct {
    int          due;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  alu;
    logic [9:0]  ctrl;
    bit          chk_data;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [9:0] obs_ctrl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  assign obs_ctrl = {bus.ex_regWrite, bus.ex_memRead, bus.ex_memWrite, bus.ex_memToReg,
                     bus.ex_aluSrc, bus.ex_branch, bus.ex_jump, bus.ex_jalr,
                     bus.ex_lui, bus.ex_auipc};

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [3:0] alu,
                              input logic [9:0] ctrl);
    exp_t e;
    e.due = 0; e.pc = pc; e.imm = imm; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.alu = alu; e.ctrl = ctrl; e.chk_data = 1'b0; e.rs1d = 32'd0; e.rs2d = 32'd0;
    return e;
  endfunction

  function automatic exp_t with_data(input exp_t e, input logic [31:0] d1, input logic [31:0] d2);
    exp_t r;
    r = e; r.chk_data = 1'b1; r.rs1d = d1; r.rs2d = d2;
    return r;
  endfunction

  function automatic exp_t bubble();
    return with_data(mk(32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 4'd0, 10'd0), 32'd0, 32'd0);
  endfunction

  task automatic push(input exp_t e, input int lat);
    exp_t t;
    t = e;
    t.due = cyc + lat;
    exp_q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
    bus.if_pc     = pc;
    bus.if_instrn = instr;
  endtask

  // Scoreboard monitor: compare due entries mid-cycle, away from the edge.
  always @(negedge clk) begin
    if (rst_) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        checks++; failures++;
        $display("FAIL sb_missed due=%0d now=%0d pc=%h", exp_q[0].due, cyc, exp_q[0].pc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (obs_ctrl !== mon_e.ctrl) begin
          failures++;
          $display("FAIL sb_ctrl pc=%h got=%h exp=%h", mon_e.pc, obs_ctrl, mon_e.ctrl);
        end
        checks++;
        if (bus.ex_rd !== mon_e.rd || bus.ex_aluCtrl !== mon_e.alu) begin
          failures++;
          $display("FAIL sb_rd_alu pc=%h got=%0d/%h exp=%0d/%h", mon_e.pc, bus.ex_rd,
                   bus.ex_aluCtrl, mon_e.rd, mon_e.alu);
        end
        checks++;
        if (bus.ex_pc !== mon_e.pc) begin
          failures++;
          $display("FAIL sb_pc got=%h exp=%h", bus.ex_pc, mon_e.pc);
        end
        checks++;
        if (bus.ex_imm !== mon_e.imm) begin
          failures++;
          $display("FAIL sb_imm pc=%h got=%h exp=%h", mon_e.pc, bus.ex_imm, mon_e.imm);
        end
        checks++;
        if (bus.ex_rs1 !== mon_e.rs1 || bus.ex_rs2 !== mon_e.rs2) begin
          failures++;
          $display("FAIL sb_rs pc=%h got=%0d,%0d exp=%0d,%0d", mon_e.pc, bus.ex_rs1,
                   bus.ex_rs2, mon_e.rs1, mon_e.rs2);
        end
        if (mon_e.chk_data) begin
          checks++;
          if (bus.ex_rs1Data !== mon_e.rs1d || bus.ex_rs2Data !== mon_e.rs2d) begin
            failures++;
            $display("FAIL sb_data pc=%h got=%h,%h exp=%h,%h", mon_e.pc, bus.ex_rs1Data,
                     bus.ex_rs2Data, mon_e.rs1d, mon_e.rs2d);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_ = 1'b0;
    drive(32'd0, NOP);
    bus.PCSrc = 1'b0; bus.wb_regWrite = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    repeat (3) step();
    checks++;
    if (bus.PCEnable !== 1'b1) begin
      failures++; $display("FAIL reset_pcenable got=%b exp=1", bus.PCEnable);
    end
    checks++;
    if (obs_ctrl !== 10'd0 || bus.ex_rd !== 5'd0 || bus.ex_pc !== 32'd0 || bus.ex_imm !== 32'd0) begin
      failures++;
      $display("FAIL reset_idex got ctrl=%h rd=%0d pc=%h imm=%h exp=all zero", obs_ctrl,
               bus.ex_rd, bus.ex_pc, bus.ex_imm);
    end
    rst_ = 1'b1;
  endtask

  task automatic test_straight_line();
    drive(32'd0, ADDI_X1);   push(mk(32'd0, 32'd5, 5'd1, 5'd0, 5'd5, 4'h0, C_ALUI), 2);
    step();
    drive(32'd4, SRAI_X4);   push(mk(32'd4, 32'h403, 5'd4, 5'd1, 5'd3, 4'hD, C_ALUI), 2);
    step();
    drive(32'd8, SUB_X5);    push(mk(32'd8, 32'd0, 5'd5, 5'd1, 5'd2, 4'h8, C_R), 2);
    step();
    drive(32'd12, ILLEGAL);  push(mk(32'd12, 32'd0, 5'd0, 5'd31, 5'd31, 4'h0, 10'd0), 2);
    step();
    drive(32'd16, NOP);      push(mk(32'd16, 32'd0, 5'd0, 5'd0, 5'd0, 4'h0, C_ALUI), 2);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.PCEnable !== 1'b1) begin
        failures++; $display("FAIL straight_pcenable cyc=%0d got=%b exp=1", i, bus.PCEnable);
      end
    end
  endtask

  task automatic test_load_use();
    // rs1 hazard: lw x2 then add x3,x2,x2 -> one bubble
    drive(32'h20, LW_X2);    push(mk(32'h20, 32'd0, 5'd2, 5'd1, 5'd0, 4'h0, C_LOAD), 2);
    step();
    drive(32'h24, ADD_X3);
    push(bubble(), 2);
    push(mk(32'h24, 32'd0, 5'd3, 5'd2, 5'd2, 4'h0, C_R), 3);
    step();
    checks++;
    if (bus.PCEnable !== 1'b0) begin
      failures++; $display("FAIL loaduse_stall got=%b exp=0", bus.PCEnable);
    end
    step();
    checks++;
    if (bus.PCEnable !== 1'b1) begin
      failures++; $display("FAIL loaduse_release got=%b exp=1", bus.PCEnable);
    end
    // rs2-only hazard through a store
    drive(32'h28, LW_X2);    push(mk(32'h28, 32'd0, 5'd2, 5'd1, 5'd0, 4'h0, C_LOAD), 2);
    step();
    drive(32'h2C, SW_X2);
    push(bubble(), 2);
    push(mk(32'h2C, 32'hFFFF_FFFC, 5'd28, 5'd1, 5'd2, 4'h0, C_STORE), 3);
    step();
    checks++;
    if (bus.PCEnable !== 1'b0) begin
      failures++; $display("FAIL store_rs2_stall got=%b exp=0", bus.PCEnable);
    end
    step();
    // I-format rs2 bits match a load rd but must not stall
    drive(32'h30, LW_X5);    push(mk(32'h30, 32'd0, 5'd5, 5'd1, 5'd0, 4'h0, C_LOAD), 2);
    step();
    drive(32'h34, ADDI_X1);  push(mk(32'h34, 32'd5, 5'd1, 5'd0, 5'd5, 4'h0, C_ALUI), 2);
    step();
    checks++;
    if (bus.PCEnable !== 1'b1) begin
      failures++; $display("FAIL itype_no_stall got=%b exp=1", bus.PCEnable);
    end
    drive(32'h38, NOP);
    repeat (3) step();
  endtask

  task automatic test_flush();
    drive(32'h40, ADDI_X1);  push(bubble(), 2);
    step();
    drive(32'h44, SUB_X5);
    bus.PCSrc = 1'b1;
    push(mk(32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 4'h0, C_ALUI), 2);
    step();
    bus.PCSrc = 1'b0;
    drive(32'h100, LUI_X1);  push(mk(32'h100, 32'h1234_5000, 5'd1, 5'd8, 5'd3, 4'h0, C_LUI), 2);
    step();
    drive(32'h104, NOP);
    repeat (2) step();
    // flush during a load-use stall: flush wins
    drive(32'h50, LW_X2);    push(mk(32'h50, 32'd0, 5'd2, 5'd1, 5'd0, 4'h0, C_LOAD), 2);
    step();
    drive(32'h54, ADD_X3);
    step();
    bus.PCSrc = 1'b1;
    drive(32'h58, BEQ_M8);
    #1;
    checks++;
    if (bus.PCEnable !== 1'b1) begin
      failures++; $display("FAIL flush_beats_stall got=%b exp=1", bus.PCEnable);
    end
    push(bubble(), 1);
    push(mk(32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 4'h0, C_ALUI), 2);
    step();
    bus.PCSrc = 1'b0;
    drive(32'h200, NOP);     push(mk(32'h200, 32'd0, 5'd0, 5'd0, 5'd0, 4'h0, C_ALUI), 2);
    checks++;
    if (bus.PCEnable !== 1'b1) begin
      failures++; $display("FAIL flush_after_pcenable got=%b exp=1", bus.PCEnable);
    end
    repeat (3) step();
  endtask

  task automatic test_bypass();
    drive(32'h60, ADD_X6);
    push(with_data(mk(32'h60, 32'd0, 5'd6, 5'd5, 5'd0, 4'h0, C_R), 32'hDEAD_BEEF, 32'd0), 2);
    step();
    bus.wb_regWrite = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
    drive(32'h64, ADD_X7);
    push(with_data(mk(32'h64, 32'd0, 5'd7, 5'd0, 5'd5, 4'h0, C_R), 32'd0, 32'hDEAD_BEEF), 2);
    step();
    bus.wb_rd = 5'd0; bus.wb_data = 32'h1234_5678;
    drive(32'h68, NOP);
    push(with_data(mk(32'h68, 32'd0, 5'd0, 5'd0, 5'd0, 4'h0, C_ALUI), 32'd0, 32'd0), 2);
    step();
    bus.wb_regWrite = 1'b0; bus.wb_data = 32'd0;
    drive(32'h6C, ADD_X6);
    push(with_data(mk(32'h6C, 32'd0, 5'd6, 5'd5, 5'd0, 4'h0, C_R), 32'hDEAD_BEEF, 32'd0), 2);
    step();
    drive(32'h70, NOP);
    repeat (3) step();
  endtask

  task automatic test_imm_back_to_back();
    drive(32'h80, BEQ_M8);   push(mk(32'h80, 32'hFFFF_FFF8, 5'd25, 5'd0, 5'd0, 4'h0, C_BRANCH), 2);
    step();
    drive(32'h84, JAL_X1);   push(mk(32'h84, 32'h0000_0800, 5'd1, 5'd0, 5'd1, 4'h0, C_JAL), 2);
    step();
    drive(32'h88, LUI_X1);   push(mk(32'h88, 32'h1234_5000, 5'd1, 5'd8, 5'd3, 4'h0, C_LUI), 2);
    step();
    drive(32'h8C, SW_X2);    push(mk(32'h8C, 32'hFFFF_FFFC, 5'd28, 5'd1, 5'd2, 4'h0, C_STORE), 2);
    step();
    drive(32'h90, NOP);
    repeat (3) step();
  endtask

  task automatic test_async_reset();
    drive(32'hA0, LW_X2);
    step();
    drive(32'hA4, ADD_X3);
    step();
    #3;
    rst_ = 1'b0;
    #1;
    checks++;
    if (obs_ctrl !== 10'd0 || bus.ex_rd !== 5'd0 || bus.ex_pc !== 32'd0) begin
      failures++;
      $display("FAIL async_reset_idex got ctrl=%h rd=%0d pc=%h exp=0", obs_ctrl, bus.ex_rd, bus.ex_pc);
    end
    checks++;
    if (bus.PCEnable !== 1'b1) begin
      failures++; $display("FAIL async_reset_pcenable got=%b exp=1", bus.PCEnable);
    end
    exp_q.delete();
    drive(32'd0, NOP);
    step();
    rst_ = 1'b1;
    drive(32'hB0, ADD_X6);
    push(with_data(mk(32'hB0, 32'd0, 5'd6, 5'd5, 5'd0, 4'h0, C_R), 32'd0, 32'd0), 2);
    step();
    drive(32'hB4, NOP);
    repeat (3) step();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    test_reset();
    test_straight_line();
    test_load_use();
    test_flush();
    test_bypass();
    test_imm_back_to_back();
    test_async_reset();
    repeat (2) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL sb_drain left=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
